// File: rtl/lsu_mem_if.sv
// Request/response bus between an initiator and the lsu_mem load/store unit.
// A request moves on an edge with req_valid && req_ready; a response moves on an edge with rsp_valid && rsp_ready.
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_mem.sv
// Word-organised data memory behind an RV32I-style load/store port with a fixed access latency.
// One request in flight at a time: IDLE accepts, WAIT counts down, RESP holds the result until consumed.
module lsu_mem #(
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    lsu_mem_if.slave   bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [0:DEPTH-1];

    logic              w_access;
    logic              w_illegal;
    logic              w_range;
    logic              w_misalign;
    logic              w_err;
    logic              w_commit;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_al;

    assign w_access = (r_state == S_WAIT) && (r_cnt == 3'd0);
    assign w_idx    = r_addr[ADDR_W+1:2];
    assign w_lane   = r_addr[1:0];
    assign w_word   = r_mem[w_idx];

    // Loads allow 000/001/010/100/101; stores only 000/001/010.
    assign w_illegal  = r_we ? (r_op >= 3'b011)
                             : ((r_op == 3'b011) || (r_op == 3'b110) || (r_op == 3'b111));
    assign w_range    = (r_addr[31:ADDR_W+2] != '0);
    assign w_misalign = ((r_op[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_op[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_err      = w_illegal || w_range || w_misalign;
    assign w_commit   = w_access && r_we && !w_err && !rst;

    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = w_word;
        case (r_op[1:0])
            2'b00:   w_load_data = r_op[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = w_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick what lands.
    always_comb begin
        w_be       = 4'b1111;
        w_wdata_al = r_wdata;
        case (r_op[1:0])
            2'b00: begin
                w_be       = 4'b0001 << w_lane;
                w_wdata_al = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be       = 4'b1111;
                w_wdata_al = r_wdata;
            end
        endcase
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_op        <= bus.req_op;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load_data;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: one instance at LATENCY=1 (functional tests) and one at LATENCY=3 (mid-access reset).
// Expected {err, rdata} pairs are queued when a request is driven and popped when its response arrives.
module tb_lsu_mem;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    logic [7:0]  mb [0:511];

    lsu_mem_if if_a ();
    lsu_mem_if if_b ();

    lsu_mem #(.ADDR_W(7), .LATENCY(1)) u_a (
        .clk         (clk),
        .rst         (rst),
        .bus         (if_a),
        .o_dbg_state (dbg_a)
    );

    lsu_mem #(.ADDR_W(7), .LATENCY(3)) u_b (
        .clk         (clk),
        .rst         (rst),
        .bus         (if_b),
        .o_dbg_state (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input bit v, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit rr);
        if (sel == 0) begin
            if_a.req_valid = v;  if_a.req_we = we;  if_a.req_op = op;
            if_a.req_addr = addr; if_a.req_wdata = wdata; if_a.rsp_ready = rr;
        end else begin
            if_b.req_valid = v;  if_b.req_we = we;  if_b.req_op = op;
            if_b.req_addr = addr; if_b.req_wdata = wdata; if_b.rsp_ready = rr;
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? if_a.req_ready : if_b.req_ready;
    endfunction

    function automatic logic rvalid_of(input int sel);
        return (sel == 0) ? if_a.rsp_valid : if_b.rsp_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? if_a.rsp_rdata : if_b.rsp_rdata;
    endfunction

    function automatic logic err_of(input int sel);
        return (sel == 0) ? if_a.rsp_err : if_b.rsp_err;
    endfunction

    // One full transaction with rsp_ready held high; lat counts cycles from the accepting edge to rsp_valid.
    task automatic run_req(input int sel, input bit we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                           output int lat);
        int n;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        drive(sel, 1'b1, we, op, addr, wdata, 1'b1);
        n = 0;
        while (!ready_of(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_of(sel)) begin
            checks++; failures++;
            $display("FAIL accept_timeout: req_ready=%b required 1", ready_of(sel));
            drive(sel, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
            return;
        end
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rvalid_of(sel)) break;
        end
        if (!rvalid_of(sel)) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rvalid_of(sel));
            return;
        end
        rdata = rdata_of(sel);
        err   = err_of(sel);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_a !== 2'd0) begin
            failures++;
            $display("FAIL reset_state_a: got %0d required 0", dbg_a);
        end
        checks++;
        if ({if_a.req_ready, if_a.rsp_valid, if_a.rsp_err} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags_a: got %b required 100", {if_a.req_ready, if_a.rsp_valid, if_a.rsp_err});
        end
        checks++;
        if (if_a.rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata_a: got %h required 0", if_a.rsp_rdata);
        end
        checks++;
        if ({dbg_b, if_b.req_ready, if_b.rsp_valid, if_b.rsp_err} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_b: got %b required 00100", {dbg_b, if_b.req_ready, if_b.rsp_valid, if_b.rsp_err});
        end
        drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_a !== 2'd0) begin
            failures++;
            $display("FAIL reset_valid_ignored: state %0d required 0", dbg_a);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'd0});
        run_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({er, rd} !== e) begin
            failures++;
            $display("FAIL sw_resp: got %b/%h required %b/%h", er, rd, e[32], e[31:0]);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL sw_latency: got %0d required 2", lat);
        end
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        run_req(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({er, rd} !== e) begin
            failures++;
            $display("FAIL lw_resp: got %b/%h required %b/%h", er, rd, e[32], e[31:0]);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL lw_latency: got %0d required 2", lat);
        end
    endtask

    task automatic test_lanes();
        logic [2:0]  ops  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, exps[i]});
            run_req(0, 1'b0, ops[i], adrs[i], 32'd0, rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if ({er, rd} !== e) begin
                failures++;
                $display("FAIL lane_%0d: got %b/%h required %b/%h", i, er, rd, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_partial();
        bit          wes  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ops  [4] = '{3'b000, 3'b010, 3'b001, 3'b010};
        logic [31:0] adrs [4] = '{32'h11, 32'h10, 32'h12, 32'h10};
        logic [31:0] wds  [4] = '{32'hFFFFFF55, 32'd0, 32'hABCD1234, 32'd0};
        logic [31:0] exps [4] = '{32'd0, 32'hDEAD55EF, 32'd0, 32'h123455EF};
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, exps[i]});
            run_req(0, wes[i], ops[i], adrs[i], wds[i], rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if ({er, rd} !== e) begin
                failures++;
                $display("FAIL partial_%0d: got %b/%h required %b/%h", i, er, rd, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_errors();
        bit          wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  ops  [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b010};
        logic [31:0] adrs [6] = '{32'h12, 32'h11, 32'h200, 32'h10, 32'h10, 32'h210};
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({1'b1, 32'd0});
            run_req(0, wes[i], ops[i], adrs[i], 32'hCAFEF00D, rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if ({er, rd} !== e) begin
                failures++;
                $display("FAIL err_%0d: got %b/%h required %b/%h", i, er, rd, e[32], e[31:0]);
            end
        end
        exp_q.push_back({1'b0, 32'h123455EF});
        run_req(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({er, rd} !== e) begin
            failures++;
            $display("FAIL err_word_unchanged: got %b/%h required %b/%h", er, rd, e[32], e[31:0]);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'h123455EF});
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (!if_a.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({if_a.rsp_valid, if_a.rsp_err, if_a.rsp_rdata} !== {1'b1, e}) begin
            failures++;
            $display("FAIL bp_first: got %b/%b/%h required 1/%b/%h",
                     if_a.rsp_valid, if_a.rsp_err, if_a.rsp_rdata, e[32], e[31:0]);
        end
        // A fresh request held during RESP must be dropped, not queued.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) drive(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0BADF00D, 1'b0);
            checks++;
            if ({if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata} !== {2'b10, e}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b %b/%h required v=1 rdy=0 %b/%h", i,
                         if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata, e[32], e[31:0]);
            end
        end
        if_a.rsp_ready = 1'b1;
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({if_a.req_ready, if_a.rsp_valid, dbg_a} !== 4'b1000) begin
            failures++;
            $display("FAIL bp_release: got rdy=%b v=%b st=%0d required rdy=1 v=0 st=0",
                     if_a.req_ready, if_a.rsp_valid, dbg_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'd0});
        run_req(1, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({er, rd} !== e) begin
            failures++;
            $display("FAIL rm_init: got %b/%h required %b/%h", er, rd, e[32], e[31:0]);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL rm_latency: got %0d required 4", lat);
        end
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h11111111, 1'b1);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (dbg_b !== 2'd1) begin
            failures++;
            $display("FAIL rm_in_wait: got %0d required 1", dbg_b);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_b, if_b.req_ready, if_b.rsp_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL rm_idle: got st=%0d rdy=%b v=%b required st=0 rdy=1 v=0",
                     dbg_b, if_b.req_ready, if_b.rsp_valid);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | if_b.rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rm_no_resp: rsp_valid seen %b required 0", seen);
        end
        exp_q.push_back({1'b0, 32'hA5A5A5A5});
        run_req(1, 1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if ({er, rd} !== e) begin
            failures++;
            $display("FAIL rm_prior_value: got %b/%h required %b/%h", er, rd, e[32], e[31:0]);
        end
    endtask

    // Byte-array reference model over bytes 0x100..0x11F; words are initialised first.
    task automatic test_random();
        logic [2:0]  lops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] e;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ex;
        logic [2:0]  op;
        bit          we;
        for (int w = 0; w < 8; w++) begin
            wd = $urandom;
            a  = 32'h100 + 32'(4 * w);
            for (int b = 0; b < 4; b++) mb[a + b] = wd[8*b +: 8];
            exp_q.push_back({1'b0, 32'd0});
            run_req(0, 1'b1, 3'b010, a, wd, rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if ({er, rd} !== e) begin
                failures++;
                $display("FAIL rnd_init_%0d: got %b/%h required %b/%h", w, er, rd, e[32], e[31:0]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom_range(0, 1));
            op = we ? 3'($urandom_range(0, 2)) : lops[$urandom_range(0, 4)];
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if (op[1:0] == 2'b01) a[0] = 1'b0;
            if (op[1:0] == 2'b10) a[1:0] = 2'b00;
            wd = $urandom;
            ex = 32'd0;
            if (we) begin
                mb[a] = wd[7:0];
                if (op != 3'b000) mb[a + 1] = wd[15:8];
                if (op == 3'b010) begin
                    mb[a + 2] = wd[23:16];
                    mb[a + 3] = wd[31:24];
                end
            end else begin
                case (op)
                    3'b000:  ex = {{24{mb[a][7]}}, mb[a]};
                    3'b100:  ex = {24'd0, mb[a]};
                    3'b001:  ex = {{16{mb[a + 1][7]}}, mb[a + 1], mb[a]};
                    3'b101:  ex = {16'd0, mb[a + 1], mb[a]};
                    default: ex = {mb[a + 3], mb[a + 2], mb[a + 1], mb[a]};
                endcase
            end
            exp_q.push_back({1'b0, ex});
            run_req(0, we, op, a, wd, rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if ({er, rd} !== e) begin
                failures++;
                $display("FAIL rnd_%0d we=%b op=%b a=%h: got %b/%h required %b/%h",
                         i, we, op, a, er, rd, e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_lanes();
        test_partial();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter ADDR_W, default 7, word-address width (2^ADDR_W 32-bit words; 128 words = 512 bytes).
REQ-002 Parameter LATENCY, default 1, wait cycles between request acceptance and response, legal range 1..7.
REQ-003 Clocking: reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_op  input  3  RV32I funct3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (SB uses bits [7:0], SH uses bits [15:0]).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  request rejected (misaligned, out of range, or illegal op).

Function
REQ-016 Request handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1; the block registers req_we, req_op, req_addr and req_wdata on that edge.
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 IDLE: req_ready=1 and rsp_valid=0. On acceptance, go to WAIT and load the wait counter with LATENCY-1.
REQ-019 WAIT: req_ready=0 and rsp_valid=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
REQ-020 Latency: rsp_valid rises exactly LATENCY+1 cycles after the accepting edge.
REQ-021 RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err stay stable until rsp_valid=1 and rsp_ready=1 on an edge, which returns the FSM to IDLE.
REQ-022 No pipelining: a new request can be accepted no earlier than the cycle after the response handshake.
REQ-023 Word index = req_addr[ADDR_W+1:2]; byte lane = req_addr[1:0]; data is little-endian.
REQ-024 Error conditions, in priority order:
- illegal op: load 011/110/111, or store with op >= 011;
- out of range: req_addr[31:ADDR_W+2] != 0;
- misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-025 On error: rsp_err=1, rsp_rdata=0, and memory is not modified.
REQ-026 Loads:
- LB/LBU select the byte at the addressed lane; LH/LHU select the halfword at lane 0 or 2; LW returns the whole word.
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
REQ-027 Stores: only the addressed byte lanes are written (SB 1 byte, SH 2 bytes, SW 4 bytes); all other bytes of the word keep their value. rsp_rdata=0, rsp_err=0.
REQ-028 The memory write commits on the WAIT→RESP edge only, exactly once per accepted store.
REQ-029 req_valid asserted outside IDLE is ignored and never queued.

Reset
REQ-030 rst asserted on an edge forces IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-031 Reset in WAIT aborts the access: the store is not committed. Reset in RESP drops the pending response.
REQ-032 Memory contents are not affected by reset.
REQ-033 req_valid during the reset cycle is not accepted.

Verification
REQ-034 Store then load: SW 0x0000_0010 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0; with LATENCY=1, rsp_valid rises 2 cycles after acceptance.
REQ-035 Lane extraction from word 0x10 = 0xDEADBEEF:
- LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE;
- LH 0x10 → 0xFFFFBEEF; LHU 0x12 → 0x0000DEAD.
REQ-036 Partial store: SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF; SH 0x12 data 0x1234, then LW 0x10 → 0x123455EF.
REQ-037 Errors, each → rsp_err=1, rsp_rdata=0, word unchanged:
- LW 0x12 (misaligned);
- SH 0x11 (misaligned);
- LW 0x200 with ADDR_W=7 (out of range);
- load op 011 (illegal).
REQ-038 Back-pressure: rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-039 Reset mid-operation: LATENCY=3, SW 0x20 data 0x11111111 with rst pulsed in WAIT → IDLE next cycle; a later LW 0x20 returns the prior value of word 0x20.
